dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Each access takes three cycles: grant (IDLE), memory access (ACCESS), ack (DONE).
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// conflict. Without it, port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [MEM_WIDTH-1:0] wdata0,
  input  logic [MEM_WIDTH-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [MEM_WIDTH-1:0] rdata0,
  output logic [MEM_WIDTH-1:0] rdata1,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0] mem_wdata,
  input  logic [MEM_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic                   port_q, port_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic [MEM_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [MEM_WIDTH-1:0]   rdata1_q, rdata1_d;
  logic                   win1;

`ifdef ARB_ROUND_ROBIN_EN
  // Port id of the most recent grant; 1 after reset so port 0 wins the first conflict.
  logic last_q, last_d;

  // On conflict, grant the port that was not granted last.
  always_comb begin
    win1 = req1 & (~req0 | ~last_q);
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  always_comb begin
    win1 = req1 & ~req0;
  end
`endif

  // Next-state, latching and memory-side outputs.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    port_d    = port_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          gnt0    = ~win1;
          gnt1    = win1;
          we_d    = win1 ? we1 : we0;
          addr_d  = win1 ? addr1 : addr0;
          wdata_d = win1 ? wdata1 : wdata0;
          port_d  = win1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = win1;
`endif
          state_d = StAccess;
        end
      end
      StAccess: begin
        mem_write = we_q;
        mem_read  = ~we_q;
        if (!we_q) begin
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
        end
        ack0_d  = ~port_q;
        ack1_d  = port_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Reset masks every combinational strobe so an in-flight write never lands.
    if (rst) begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
